// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters,
// with owner-tag tracking and credit-guarded per-requester response FIFOs.
module mul_arb #(
    parameter int XLEN     = 64,
    parameter int LAT      = 2,
    parameter int RSPDEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Req0Valid,
    output logic                Req0Ready,
    input  logic [XLEN-1:0]     Req0A,
    input  logic [XLEN-1:0]     Req0B,
    input  logic [2:0]          Req0Funct3,
    input  logic                Req1Valid,
    output logic                Req1Ready,
    input  logic [XLEN-1:0]     Req1A,
    input  logic [XLEN-1:0]     Req1B,
    input  logic [2:0]          Req1Funct3,
    output logic                Rsp0Valid,
    input  logic                Rsp0Ready,
    output logic [2*XLEN-1:0]   Rsp0Prod,
    output logic                Rsp1Valid,
    input  logic                Rsp1Ready,
    output logic [2*XLEN-1:0]   Rsp1Prod,
    output logic                MulEn,
    output logic [XLEN-1:0]     MulA,
    output logic [XLEN-1:0]     MulB,
    output logic [2:0]          MulFunct3,
    input  logic [2*XLEN-1:0]   MulProd
);

    localparam int PWID = 2 * XLEN;
    localparam int PTRW = (RSPDEPTH > 1) ? $clog2(RSPDEPTH) : 1;
    localparam int CNTW = $clog2(RSPDEPTH + 1);
    localparam int OCCW = $clog2(RSPDEPTH + LAT + 1);

    logic            prio;
    logic [LAT-1:0]  tag_valid;
    logic [LAT-1:0]  tag_id;
    logic [PWID-1:0] mem [2][RSPDEPTH];
    logic [PTRW-1:0] head [2];
    logic [PTRW-1:0] tail [2];
    logic [CNTW-1:0] count [2];
    logic [OCCW-1:0] occ [2];
    logic [1:0]      credit;
    logic [1:0]      elig;
    logic [1:0]      grant;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      nonempty;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(RSPDEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // Occupancy counts buffered results plus tagged ops still in the multiplier,
    // so an issued op always has a FIFO slot reserved when it lands.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            occ[i] = OCCW'(count[i]);
            for (int k = 0; k < LAT; k++) begin
                if (tag_valid[k] && (tag_id[k] == 1'(i))) begin
                    occ[i] = occ[i] + OCCW'(1);
                end
            end
            credit[i]   = occ[i] < OCCW'(RSPDEPTH);
            nonempty[i] = count[i] != '0;
            push[i]     = tag_valid[LAT-1] && (tag_id[LAT-1] == 1'(i));
        end
    end

    always_comb begin
        elig[0]  = reset && Req0Valid && credit[0];
        elig[1]  = reset && Req1Valid && credit[1];
        grant[0] = elig[0] && (!elig[1] || !prio);
        grant[1] = elig[1] && (!elig[0] || prio);
        pop[0]   = nonempty[0] && Rsp0Ready;
        pop[1]   = nonempty[1] && Rsp1Ready;
    end

    assign Req0Ready = grant[0];
    assign Req1Ready = grant[1];
    assign MulEn     = |grant;
    assign MulA      = grant[0] ? Req0A      : (grant[1] ? Req1A      : '0);
    assign MulB      = grant[0] ? Req0B      : (grant[1] ? Req1B      : '0);
    assign MulFunct3 = grant[0] ? Req0Funct3 : (grant[1] ? Req1Funct3 : 3'b000);

    assign Rsp0Valid = nonempty[0];
    assign Rsp1Valid = nonempty[1];
    assign Rsp0Prod  = nonempty[0] ? mem[0][head[0]] : '0;
    assign Rsp1Prod  = nonempty[1] ? mem[1][head[1]] : '0;

    // Pointer always moves to the requester that was not just served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio      <= 1'b0;
            tag_valid <= '0;
            tag_id    <= '0;
            for (int i = 0; i < 2; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            if (grant[0]) begin
                prio <= 1'b1;
            end else if (grant[1]) begin
                prio <= 1'b0;
            end
            tag_valid[0] <= MulEn;
            tag_id[0]    <= grant[1];
            for (int k = 1; k < LAT; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    tail[i] <= ptr_inc(tail[i]);
                end
                if (pop[i]) begin
                    head[i] <= ptr_inc(head[i]);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNTW'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][tail[i]] <= MulProd;
            end
        end
    end

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb: random operands, a behavioural multiplier,
// and per-requester expected/received product queues.
module tb_mul_arb;

    localparam int XLEN     = 64;
    localparam int LAT      = 2;
    localparam int RSPDEPTH = 4;
    localparam int PW       = 2 * XLEN;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            Req0Valid, Req0Ready, Req1Valid, Req1Ready;
    logic [XLEN-1:0] Req0A, Req0B, Req1A, Req1B;
    logic [2:0]      Req0Funct3, Req1Funct3;
    logic            Rsp0Valid, Rsp0Ready, Rsp1Valid, Rsp1Ready;
    logic [PW-1:0]   Rsp0Prod, Rsp1Prod;
    logic            MulEn;
    logic [XLEN-1:0] MulA, MulB;
    logic [2:0]      MulFunct3;
    logic [PW-1:0]   MulProd;

    int vectors = 0;
    int miscompares = 0;

    logic [PW-1:0] exp0[$], exp1[$], got0[$], got1[$];
    int acc0, acc1, pops0, pops1;
    bit ovf = 1'b0;

    mul_arb #(.XLEN(XLEN), .LAT(LAT), .RSPDEPTH(RSPDEPTH)) dut (
        .clk(clk), .reset(reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B), .Req0Funct3(Req0Funct3),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B), .Req1Funct3(Req1Funct3),
        .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp0Prod(Rsp0Prod),
        .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready), .Rsp1Prod(Rsp1Prod),
        .MulEn(MulEn), .MulA(MulA), .MulB(MulB), .MulFunct3(MulFunct3), .MulProd(MulProd)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mul_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [2:0] f);
        logic signed [PW:0] ea, eb, p;
        ea = (f[1:0] == 2'b11) ? {{(XLEN+1){1'b0}}, a} : {{(XLEN+1){a[XLEN-1]}}, a};
        eb = (f[1] == 1'b1)    ? {{(XLEN+1){1'b0}}, b} : {{(XLEN+1){b[XLEN-1]}}, b};
        p = ea * eb;
        return p[PW-1:0];
    endfunction

    function automatic logic [XLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Multiplier stand-in: deliberately not reset, so stale products still arrive.
    logic [PW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mul_ref(MulA, MulB, MulFunct3);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign MulProd = pipe[LAT-1];

    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            if (Req0Ready) begin exp0.push_back(mul_ref(Req0A, Req0B, Req0Funct3)); acc0++; end
            if (Req1Ready) begin exp1.push_back(mul_ref(Req1A, Req1B, Req1Funct3)); acc1++; end
            if (Rsp0Valid && Rsp0Ready) begin got0.push_back(Rsp0Prod); pops0++; end
            if (Rsp1Valid && Rsp1Ready) begin got1.push_back(Rsp1Prod); pops1++; end
            if ((acc0 - pops0 > RSPDEPTH) || (acc1 - pops1 > RSPDEPTH)) ovf = 1'b1;
        end
    end

    always @(negedge reset) begin
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
        acc0 = 0; acc1 = 0; pops0 = 0; pops1 = 0;
    end

    task automatic idle_inputs();
        Req0Valid = 1'b0; Req0A = '0; Req0B = '0; Req0Funct3 = 3'b000;
        Req1Valid = 1'b0; Req1A = '0; Req1B = '0; Req1Funct3 = 3'b000;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        Rsp0Ready = 1'b1;
        Rsp1Ready = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk);
        idle_inputs();
        Rsp0Ready = 1'b1;
        Rsp1Ready = 1'b1;
        repeat (LAT + RSPDEPTH + 4) @(negedge clk);
        #5;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        Req0Valid = 1'b1; Req0A = rnd64() | 64'd1; Req0B = rnd64() | 64'd1; Req0Funct3 = 3'b001;
        Req1Valid = 1'b1; Req1A = rnd64() | 64'd1; Req1B = rnd64() | 64'd1; Req1Funct3 = 3'b011;
        Rsp0Ready = 1'b1; Rsp1Ready = 1'b1;
        #2;
        vectors++;
        if ({Req0Ready, Req1Ready, MulEn, Rsp0Valid, Rsp1Valid} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {Req0Ready, Req1Ready, MulEn, Rsp0Valid, Rsp1Valid});
        end
        vectors++;
        if ({MulA, MulB, MulFunct3} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mul: got A=%h B=%h F=%b expected 0", MulA, MulB, MulFunct3);
        end
        vectors++;
        if ({Rsp0Prod, Rsp1Prod} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_prod: got %h / %h expected 0", Rsp0Prod, Rsp1Prod);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        Req0Valid = 1'b1; Req0A = 64'd7; Req0B = 64'd6; Req0Funct3 = 3'b000;
        #2;
        vectors++;
        if ({Req0Ready, MulEn, Req1Ready} !== 3'b110 || MulA !== 64'd7) begin
            miscompares++;
            $display("[TB] FAIL single_issue: got rdy/en/rdy1=%b A=%h expected 110 A=7",
                     {Req0Ready, MulEn, Req1Ready}, MulA);
        end
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk);
            idle_inputs();
            #2;
            vectors++;
            if (Rsp0Valid !== (c == LAT + 1) || Rsp1Valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL single_valid cycle %0d: got %b%b expected %b0",
                         c, Rsp0Valid, Rsp1Valid, (c == LAT + 1));
            end
            if (c == LAT + 1) begin
                vectors++;
                if (Rsp0Prod !== 128'd42) begin
                    miscompares++;
                    $display("[TB] FAIL single_prod: got %h expected 42", Rsp0Prod);
                end
            end
        end
    endtask

    task automatic test_alternate();
        logic [XLEN-1:0] a0, b0, a1, b1;
        logic [2:0] f0, f1;
        apply_reset();
        a0 = 64'h8000_0000_0000_0000; b0 = 64'd4; f0 = 3'b011;
        a1 = 64'hFFFF_FFFF_FFFF_FFFD; b1 = 64'd5; f1 = 3'b000;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            Req0Valid = 1'b1; Req0A = a0; Req0B = b0; Req0Funct3 = f0;
            Req1Valid = 1'b1; Req1A = a1; Req1B = b1; Req1Funct3 = f1;
            #2;
            vectors++;
            if ({Req1Ready, Req0Ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("[TB] FAIL alt_grant cycle %0d: got %b expected %b", c,
                         {Req1Ready, Req0Ready}, (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (Req0Ready) begin a0 = rnd64(); b0 = rnd64(); f0 = 3'($urandom_range(0, 3)); end
            if (Req1Ready) begin a1 = rnd64(); b1 = rnd64(); f1 = 3'($urandom_range(0, 3)); end
        end
        drain();
        vectors++;
        if (got0.size() != 8 || got1.size() != 8 || exp0.size() != 8 || exp1.size() != 8) begin
            miscompares++;
            $display("[TB] FAIL alt_count: got %0d/%0d accepted %0d/%0d expected 8 each",
                     got0.size(), got1.size(), exp0.size(), exp1.size());
        end
        for (int k = 0; k < got0.size() && k < exp0.size(); k++) begin
            vectors++;
            if (got0[k] !== exp0[k]) begin
                miscompares++;
                $display("[TB] FAIL alt_rsp0[%0d]: got %h expected %h", k, got0[k], exp0[k]);
            end
        end
        for (int k = 0; k < got1.size() && k < exp1.size(); k++) begin
            vectors++;
            if (got1[k] !== exp1[k]) begin
                miscompares++;
                $display("[TB] FAIL alt_rsp1[%0d]: got %h expected %h", k, got1[k], exp1[k]);
            end
        end
        if (got0.size() > 0 && got1.size() > 0) begin
            vectors++;
            if (got0[0][PW-1:XLEN] !== 64'd2 || got1[0][XLEN-1:0] !== 64'hFFFF_FFFF_FFFF_FFF1) begin
                miscompares++;
                $display("[TB] FAIL alt_first: got mulhu %h mul %h expected 2 and -15",
                         got0[0][PW-1:XLEN], got1[0][XLEN-1:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        logic last_rdy;
        logic [XLEN-1:0] a0, b0;
        apply_reset();
        Rsp0Ready = 1'b0;
        accepted = 0;
        last_rdy = 1'b0;
        a0 = rnd64(); b0 = rnd64();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            Req0Valid = 1'b1; Req0A = a0; Req0B = b0; Req0Funct3 = 3'b010;
            #2;
            last_rdy = Req0Ready;
            if (Req0Ready) begin accepted++; a0 = rnd64(); b0 = rnd64(); end
        end
        vectors++;
        if (accepted != RSPDEPTH || last_rdy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_fill: got %0d accepted, ready=%b expected %0d, ready=0",
                     accepted, last_rdy, RSPDEPTH);
        end
        @(negedge clk);
        Rsp0Ready = 1'b1;
        #2;
        vectors++;
        if ({Rsp0Valid, Req0Ready} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL bp_pop: got valid/ready=%b expected 10", {Rsp0Valid, Req0Ready});
        end
        @(negedge clk);
        Rsp0Ready = 1'b0;
        #2;
        vectors++;
        if (Req0Ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_credit: got ready=%b expected 1", Req0Ready);
        end
        @(negedge clk);
        Req0A = rnd64(); Req0B = rnd64();
        #2;
        vectors++;
        if (Req0Ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_refull: got ready=%b expected 0", Req0Ready);
        end
        drain();
        vectors++;
        if (got0.size() != RSPDEPTH + 1 || exp0.size() != RSPDEPTH + 1) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d accepted %0d expected %0d",
                     got0.size(), exp0.size(), RSPDEPTH + 1);
        end
        for (int k = 0; k < got0.size() && k < exp0.size(); k++) begin
            vectors++;
            if (got0[k] !== exp0[k]) begin
                miscompares++;
                $display("[TB] FAIL bp_rsp0[%0d]: got %h expected %h", k, got0[k], exp0[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int accepted, cycles;
        logic [XLEN-1:0] a0, b0;
        logic [2:0] f0;
        apply_reset();
        accepted = 0;
        cycles = 0;
        a0 = rnd64(); b0 = rnd64(); f0 = 3'($urandom_range(0, 3));
        while (accepted < 10 && cycles < 300) begin
            @(negedge clk);
            cycles++;
            Req0Valid = 1'b1; Req0A = a0; Req0B = b0; Req0Funct3 = f0;
            Req1Valid = 1'($urandom_range(0, 1));
            Req1A = rnd64(); Req1B = rnd64(); Req1Funct3 = 3'($urandom_range(0, 7));
            Rsp0Ready = 1'($urandom_range(0, 1));
            Rsp1Ready = 1'($urandom_range(0, 1));
            #2;
            if (Req0Ready) begin
                accepted++;
                a0 = rnd64(); b0 = rnd64(); f0 = 3'($urandom_range(0, 3));
            end
        end
        vectors++;
        if (accepted != 10) begin
            miscompares++;
            $display("[TB] FAIL wrap_timeout: got %0d accepted expected 10", accepted);
        end
        drain();
        vectors++;
        if (got0.size() != 10 || exp0.size() != 10 || got1.size() != exp1.size()) begin
            miscompares++;
            $display("[TB] FAIL wrap_count: got %0d/%0d accepted %0d/%0d expected 10 and equal",
                     got0.size(), got1.size(), exp0.size(), exp1.size());
        end
        for (int k = 0; k < got0.size() && k < exp0.size(); k++) begin
            vectors++;
            if (got0[k] !== exp0[k]) begin
                miscompares++;
                $display("[TB] FAIL wrap_rsp0[%0d]: got %h expected %h", k, got0[k], exp0[k]);
            end
        end
        for (int k = 0; k < got1.size() && k < exp1.size(); k++) begin
            vectors++;
            if (got1[k] !== exp1[k]) begin
                miscompares++;
                $display("[TB] FAIL wrap_rsp1[%0d]: got %h expected %h", k, got1[k], exp1[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int accepted;
        logic [PW-1:0] want;
        apply_reset();
        Rsp0Ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            Req0Valid = 1'b1; Req0A = rnd64(); Req0B = rnd64(); Req0Funct3 = 3'b001;
            #2;
            if (Req0Ready) accepted++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (accepted != 3 || Rsp0Valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_setup: got %0d accepted valid=%b expected 3 valid=1",
                     accepted, Rsp0Valid);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({Rsp0Valid, Rsp1Valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL mid_flush: got %b expected 00", {Rsp0Valid, Rsp1Valid});
        end
        #1;
        reset = 1'b1;
        Rsp0Ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #2;
            vectors++;
            if ({Rsp0Valid, Rsp1Valid} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL mid_stale cycle %0d: got %b expected 00", c, {Rsp0Valid, Rsp1Valid});
            end
        end
        @(negedge clk);
        Req0Valid = 1'b1; Req0A = rnd64(); Req0B = rnd64(); Req0Funct3 = 3'($urandom_range(0, 3));
        want = mul_ref(Req0A, Req0B, Req0Funct3);
        #2;
        vectors++;
        if (Req0Ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_issue: got ready=%b expected 1", Req0Ready);
        end
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            idle_inputs();
            #2;
            vectors++;
            if (Rsp0Valid !== (c == LAT + 1)) begin
                miscompares++;
                $display("[TB] FAIL mid_lat cycle %0d: got %b expected %b", c, Rsp0Valid, (c == LAT + 1));
            end
            if (c == LAT + 1) begin
                vectors++;
                if (Rsp0Prod !== want) begin
                    miscompares++;
                    $display("[TB] FAIL mid_prod: got %h expected %h", Rsp0Prod, want);
                end
            end
        end
    endtask

    task automatic test_pointer();
        apply_reset();
        @(negedge clk);
        Req0Valid = 1'b1; Req0A = rnd64(); Req0B = rnd64();
        #2;
        vectors++;
        if (Req0Ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ptr_solo0: got %b expected 1", Req0Ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            Req0Valid = 1'b0;
            Req1Valid = 1'b1; Req1A = rnd64(); Req1B = rnd64(); Req1Funct3 = 3'b011;
            #2;
            vectors++;
            if (Req1Ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL ptr_solo1 op %0d: got %b expected 1", c, Req1Ready);
            end
        end
        @(negedge clk);
        Req0Valid = 1'b1; Req0A = rnd64(); Req0B = rnd64();
        Req1A = rnd64(); Req1B = rnd64();
        #2;
        vectors++;
        if ({Req1Ready, Req0Ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL ptr_contend: got %b expected 01", {Req1Ready, Req0Ready});
        end
        @(negedge clk);
        Req0A = rnd64(); Req0B = rnd64();
        #2;
        vectors++;
        if ({Req1Ready, Req0Ready} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL ptr_next: got %b expected 10", {Req1Ready, Req0Ready});
        end
        drain();
        vectors++;
        if (got0.size() != 2 || got1.size() != 4 || got0 != exp0 || got1 != exp1) begin
            miscompares++;
            $display("[TB] FAIL ptr_streams: got %0d/%0d results expected 2/4 matching",
                     got0.size(), got1.size());
        end
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fifo_overflow: got %b expected 0", ovf);
        end
    endtask

    initial begin
        idle_inputs();
        Rsp0Ready = 1'b0;
        Rsp1Ready = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_pointer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
